mem_bus_arbiter: RTL and testbench

- Arbitrates the single burst-oriented system memory port between two requesters: the instruction-fetch refill path (read-only) and the data refill/writeback path (read or write).
- Sits in the sys_clk domain between the CPU-side memory clients and the system memory model.
- Locks the grant for a whole burst of READ_BURST_LEN or WRITE_BURST_LEN beats.
- Uses round-robin priority so that neither requester starves.

---
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester burst arbiter for the system memory port: instruction refill
// (read-only) vs data refill/writeback, round-robin on ties, grant locked per burst.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wready,
    output logic                  d_rvalid,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wready
);

    localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_BURST_LEN - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RD, S_WR, S_DONE} state_e;

    // owner is one-hot {data, inst}; 2'b00 means no owner yet
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              owner_q, owner_d;
    logic                    last_d_q, last_d_d;   // 1: DATA owned the previous burst
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_NONE;
            last_d_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_d_q <= last_d_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d_d = last_d_q;
        we_d     = we_q;
        addr_d   = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // DATA wins when alone, or on a tie if INST went last
                    if (d_req && (!i_req || !last_d_q)) begin
                        owner_d = OWN_D;
                        we_d    = d_we;
                        addr_d  = d_addr;
                    end else begin
                        owner_d = OWN_I;
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                    end
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mem_ack) state_d = we_q ? S_WR : S_RD;
            end
            S_RD: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == RD_LAST) state_d = S_DONE;
                end
            end
            S_WR: begin
                if (mem_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WR_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d_d = owner_q[1];
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == S_ADDR);
        i_rvalid = (state_q == S_RD) && (owner_q == OWN_I) && mem_rvalid;
        d_rvalid = (state_q == S_RD) && (owner_q == OWN_D) && mem_rvalid;
        d_wready = (state_q == S_WR) && mem_wready;
        i_done   = (state_q == S_DONE) && (owner_q == OWN_I);
        d_done   = (state_q == S_DONE) && (owner_q == OWN_D);
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = d_wdata;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of bursts driven through a memory model,
// read beats and write beats checked through scoreboard queues.
module tb_mem_bus_arbiter;

    logic        sys_clk, sys_rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_rvalid, i_done, d_wready, d_rvalid, d_done;
    logic [31:0] rdata, mem_addr, mem_rdata, mem_wdata;
    logic        mem_req, mem_we, mem_ack, mem_rvalid, mem_wready;

    mem_bus_arbiter dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wready(d_wready), .d_rvalid(d_rvalid), .d_done(d_done), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        ireq, dreq, dwe;
        logic [31:0] iaddr, daddr;
        int          ack_dly;
        logic        stray, stall;
        logic        exp_d, exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct packed {
        logic        own_d;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] wq[$];
    vec_t        vt[7];
    vec_t        rst_v;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Read beats forwarded by the DUT are matched against the model's queue
    always @(negedge sys_clk) begin : mon
        sb_t e;
        if (i_rvalid || d_rvalid) begin
            chk("rvalid_exclusive", {31'd0, i_rvalid & d_rvalid}, 32'd0);
            chk("rvalid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rvalid_owner", {31'd0, d_rvalid}, {31'd0, e.own_d});
                chk("rdata", rdata, e.data);
            end
        end
    end

    task automatic run_burst(input vec_t v);
        int b, c;
        i_req = v.ireq; d_req = v.dreq; d_we = v.dwe;
        i_addr = v.iaddr; d_addr = v.daddr;
        tick();
        for (int k = 0; k < v.ack_dly; k++) begin
            mem_ack = 1'b0;
            mem_rvalid = v.stray && (k == 1);
            mem_rdata = 32'hBAD0_BAD0;
            @(negedge sys_clk);
            chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
            chk("mem_addr_wait", mem_addr, v.exp_addr);
            chk("mem_we_wait", {31'd0, mem_we}, {31'd0, v.exp_we});
            tick();
        end
        mem_rvalid = 1'b0;
        mem_ack = 1'b1;
        @(negedge sys_clk);
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, v.exp_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
        tick();
        mem_ack = 1'b0;
        b = 0; c = 0;
        while (b < 8 && c < 64) begin
            if (v.exp_we) begin
                mem_wready = v.stall ? (c % 2 == 1) : 1'b1;
                d_wdata = 32'hA0 + b;
                if (mem_wready) begin
                    wq.push_back(32'hA0 + b);
                    b++;
                end
            end else begin
                mem_rvalid = !v.stall || (c % 2 == 0);
                mem_rdata = 32'hD000_0000 + v.exp_addr + b;
                if (mem_rvalid) begin
                    sb_q.push_back({v.exp_d, mem_rdata});
                    b++;
                end
            end
            @(negedge sys_clk);
            chk("done_early", {30'd0, i_done, d_done}, 32'd0);
            chk("mem_req_beat", {31'd0, mem_req}, 32'd0);
            if (v.exp_we) begin
                chk("d_wready", {31'd0, d_wready}, {31'd0, mem_wready});
                if (mem_wready && wq.size() != 0) chk("mem_wdata", mem_wdata, wq.pop_front());
            end
            tick();
            c++;
        end
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
        @(negedge sys_clk);
        chk("i_done", {31'd0, i_done}, {31'd0, !v.exp_d});
        chk("d_done", {31'd0, d_done}, {31'd0, v.exp_d});
        chk("beats_missing", sb_q.size(), 32'd0);
        chk("mem_req_done", {31'd0, mem_req}, 32'd0);
        tick();
        @(negedge sys_clk);
        chk("done_width", {30'd0, i_done, d_done}, 32'd0);
        chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200};
        vt[2] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h100, 1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0,  5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300};
        rst_v = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0,   0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80};

        sys_rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        // strobes held high in reset must not leak through
        mem_rvalid = 1'b1; mem_wready = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_done", {30'd0, i_done, d_done}, 32'd0);
        chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        chk("rst_wready", {31'd0, d_wready}, 32'd0);
        mem_rvalid = 1'b0; mem_wready = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(vt[i]);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        // Reset after the third read beat abandons the burst silently
        i_req = 1'b1; i_addr = 32'h80;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hD000_0080 + b;
            sb_q.push_back({1'b0, mem_rdata});
            @(negedge sys_clk);
            tick();
        end
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", {31'd0, i_rvalid}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_beats", sb_q.size(), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge sys_clk);
            chk("midrst_done", {30'd0, i_done, d_done}, 32'd0);
        end
        mem_rvalid = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        run_burst(rst_v);
        i_req = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
